// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into SEGS registered ripple segments.
// Optional add/subtract mode with signed overflow flag: define ADDSUB_EN.
module pipelined_rca_adder #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int SEG_W = (SEGS > 0 && WIDTH >= SEGS) ? WIDTH / SEGS : 1;

    if (SEGS < 1 || SEGS > WIDTH || (WIDTH % SEGS) != 0) begin : g_cfg_err
        $error("pipelined_rca_adder: WIDTH (%0d) must be a multiple of SEGS (%0d), 1 <= SEGS <= WIDTH",
               WIDTH, SEGS);
    end

    // One segment of full adders; result is {carry_out, partial_sum}.
    function automatic logic [SEG_W:0] ripple_add(input logic [SEG_W-1:0] x,
                                                  input logic [SEG_W-1:0] y,
                                                  input logic             ci);
        logic [SEG_W-1:0] s;
        logic             c;
        s = {SEG_W{1'b0}};
        c = ci;
        for (int i = 0; i < SEG_W; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;

    // Per-stage registers: skewed operands, accumulated partial sum, carry, valid.
    logic [WIDTH-1:0] a_r     [SEGS];
    logic [WIDTH-1:0] b_r     [SEGS];
    logic [WIDTH-1:0] sum_r   [SEGS];
    logic             carry_r [SEGS];
    logic             valid_r [SEGS];

    // What each stage sees on its input side (ports for stage 0, previous stage otherwise).
    logic [WIDTH-1:0] stg_a_s   [SEGS];
    logic [WIDTH-1:0] stg_b_s   [SEGS];
    logic [WIDTH-1:0] stg_sum_s [SEGS];
    logic             stg_c_s   [SEGS];
    logic             stg_v_s   [SEGS];

`ifdef ADDSUB_EN
    // Subtraction is a + ~b + cin, so b is inverted once on entry.
    assign b_eff_s = b ^ {WIDTH{sub}};
`else
    assign b_eff_s = b;
`endif

    assign adv_s     = !valid_r[SEGS-1] | out_ready;
    assign in_ready  = adv_s;
    assign out_valid = valid_r[SEGS-1];
    assign sum       = sum_r[SEGS-1];
    assign carry     = carry_r[SEGS-1];

`ifdef ADDSUB_EN
    // Signed overflow: operands of equal sign producing a result of the other sign.
    assign ovf = (a_r[SEGS-1][WIDTH-1] == b_r[SEGS-1][WIDTH-1]) &
                 (sum_r[SEGS-1][WIDTH-1] != a_r[SEGS-1][WIDTH-1]);
`endif

    for (genvar k = 0; k < SEGS; k++) begin : g_stage
        logic [SEG_W:0]   seg_res_s;
        logic [WIDTH-1:0] nxt_sum_s;

        if (k == 0) begin : g_src
            assign stg_a_s[k]   = a;
            assign stg_b_s[k]   = b_eff_s;
            assign stg_sum_s[k] = {WIDTH{1'b0}};
            assign stg_c_s[k]   = cin;
            assign stg_v_s[k]   = in_valid;
        end else begin : g_chain
            assign stg_a_s[k]   = a_r[k-1];
            assign stg_b_s[k]   = b_r[k-1];
            assign stg_sum_s[k] = sum_r[k-1];
            assign stg_c_s[k]   = carry_r[k-1];
            assign stg_v_s[k]   = valid_r[k-1];
        end

        // Add this stage's segment and merge it into the partial sum.
        always_comb begin
            nxt_sum_s = stg_sum_s[k];
            seg_res_s = ripple_add(stg_a_s[k][k*SEG_W +: SEG_W],
                                   stg_b_s[k][k*SEG_W +: SEG_W],
                                   stg_c_s[k]);
            nxt_sum_s[k*SEG_W +: SEG_W] = seg_res_s[SEG_W-1:0];
        end

        // Stage register; the whole pipeline moves only when the output can drain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r[k] <= 1'b0;
                carry_r[k] <= 1'b0;
                a_r[k]     <= {WIDTH{1'b0}};
                b_r[k]     <= {WIDTH{1'b0}};
                sum_r[k]   <= {WIDTH{1'b0}};
            end else if (adv_s) begin
                valid_r[k] <= stg_v_s[k];
                carry_r[k] <= seg_res_s[SEG_W];
                a_r[k]     <= stg_a_s[k];
                b_r[k]     <= stg_b_s[k];
                sum_r[k]   <= nxt_sum_s;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Scoreboard bench for pipelined_rca_adder: expected results queued on input
// transfer, checked by an independent monitor on output transfer.
module tb_pipelined_rca_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, out_valid, out_ready, carry;
    logic [W-1:0] a, b, sum;
    logic         sub_v;
    logic         ovf_v;

    int tests = 0, fails = 0;
    int cyc = 0, last_pop = -10, run = 0, max_run = 0;
    logic         hold_v = 1'b0;
    logic [W:0]   hold_d;
    logic [W+1:0] q[$];

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(W), .SEGS(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef ADDSUB_EN
        .sub(sub_v), .ovf(ovf_v),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's mathematical meaning.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        longint lim, ux, uy, sx, sy, tot, st;
        logic   o;
        lim = 64'sd1 <<< W;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = x[W-1] ? ux - lim : ux;
        sy  = y[W-1] ? uy - lim : uy;
        if (s) begin
            uy = lim - 64'sd1 - uy;
            sy = -sy - 64'sd1;
        end
        tot = ux + uy + longint'(ci);
        st  = sx + sy + longint'(ci);
        o   = (st > (lim / 64'sd2) - 64'sd1) || (st < -(lim / 64'sd2));
        return {o, tot[W], tot[W-1:0]};
    endfunction

    // Monitor: stall stability, output pops, input pushes.
    always @(negedge clk) begin
        logic [W+1:0] e;
        cyc++;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("stall_hold", {out_valid, carry, sum}, {1'b1, hold_d});
            hold_v = out_valid && !out_ready;
            hold_d = {carry, sum};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got sum=%0h with no pending result", sum);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e[W-1:0]);
                    chk("carry", carry, e[W]);
`ifdef ADDSUB_EN
                    chk("ovf", ovf_v, e[W+1]);
`endif
                    run = (last_pop == cyc - 1) ? run + 1 : 1;
                    if (run > max_run) max_run = run;
                    last_pop = cyc;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub_v));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((q.size() != 0 || out_valid) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    task automatic run_single(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                              input logic xs, input logic [W-1:0] es, input logic ec,
                              input logic eo, input int el);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = xa; b = xb; cin = xc; sub_v = xs;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", lat, el);
        chk("sum_dir", sum, es);
        chk("carry_dir", carry, ec);
`ifdef ADDSUB_EN
        chk("ovf_dir", ovf_v, eo);
`else
        if (eo) $display("note: ovf expectation skipped in adder-only build");
`endif
        drain();
    endtask

    initial begin
        int issued, guard;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        tick();

        // Wrap-around and latency
        run_single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, S);

        // Back-to-back stream
        max_run = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = W'(i * 32'h1111); b = 16'h0F0F; cin = 1'b0; sub_v = 1'b0;
            tick();
        end
        drain();
        chk("b2b_consecutive", max_run, 8);

        // Random traffic with random backpressure
        issued = 0;
        guard  = 0;
        while (issued < 1000 && guard < 20000) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 2) != 0;
            a = W'($urandom); b = W'($urandom); cin = 1'(($urandom % 2));
`ifdef ADDSUB_EN
            sub_v = 1'(($urandom % 2));
`endif
            #1;
            if (in_valid && in_ready) issued++;
            tick();
            guard++;
        end
        chk("random_issued", issued, 1000);
        drain();

        // Reset with operations in flight
        out_ready = 1'b1;
        sub_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        q.delete();
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (2 * S + 2) tick();
        run_single(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, S);

`ifdef ADDSUB_EN
        run_single(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, S);
        run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, S);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
